// File: rtl/dma_bus_pkg.sv
// Shared types and constants for the DMA bus arbiter.
// States, owner encoding and the bus address map.
package dma_bus_pkg;

    localparam int CNT_W = 6;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CPU  = 3'd1;
    localparam logic [2:0] ST_IRQ1 = 3'd2;
    localparam logic [2:0] ST_IRQ2 = 3'd3;
    localparam logic [2:0] ST_DMA  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CPU  = ST_CPU,
        S_IRQ1 = ST_IRQ1,
        S_IRQ2 = ST_IRQ2,
        S_DMA  = ST_DMA
    } state_t;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA,
        OWN_IO1,
        OWN_IO2
    } owner_t;

    localparam logic [7:0] MEM_BASE = 8'd0;
    localparam logic [7:0] MEM_TOP  = 8'd191;
    localparam logic [7:0] IO1_BASE = 8'd192;
    localparam logic [7:0] IO1_TOP  = 8'd223;
    localparam logic [7:0] IO2_BASE = 8'd224;
    localparam logic [7:0] IO2_TOP  = 8'd255;

    typedef enum logic [1:0] {
        REG_MEM,
        REG_IO1,
        REG_IO2
    } region_t;

    function automatic region_t addr_region(input logic [7:0] a);
        if (a <= MEM_TOP)      return REG_MEM;
        else if (a <= IO1_TOP) return REG_IO1;
        else                   return REG_IO2;
    endfunction

    function automatic owner_t state_owner(input state_t s);
        unique case (s)
            S_CPU:   return OWN_CPU;
            S_DMA:   return OWN_DMA;
            S_IRQ1:  return OWN_IO1;
            S_IRQ2:  return OWN_IO2;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Loadable down-counter with decrement enable and zero flag.
// Saturates at zero; load wins over decrement.
module arb_burst_counter
    import dma_bus_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Bus arbiter for processor, DMA engine and two interrupt sources.
// One-hot registered grants, bounded DMA tenures, DMA fairness flag.
module dma_bus_arbiter
    import dma_bus_pkg::*;
#(
    parameter int CPU_SLOT     = 1,
    parameter int IRQ_SLOT     = 1,
    parameter int DMA_MAX_HOLD = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cpu_req,
    input  logic             dma_req,
    input  logic [CNT_W-1:0] dma_count,
    input  logic             dma_word_done,
    input  logic             IOIP1,
    input  logic             IOIP2,
    output logic             cpu_grant,
    output logic             grant,
    output logic             IOAck1,
    output logic             IOAck2,
    output logic             busybus,
    output logic [CNT_W-1:0] dma_remaining
);

    state_t           r_state;
    state_t           w_next;
    logic             r_fair;
    logic             w_fair_next;
    logic [CNT_W-1:0] r_slot;
    logic [CNT_W-1:0] w_slot_next;

    logic             r_cpu_grant;
    logic             r_grant;
    logic             r_ack1;
    logic             r_ack2;

    logic             w_rem_load;
    logic [CNT_W-1:0] w_rem_val;
    logic             w_rem_dec;
    logic             w_rem_zero;
    logic             w_hold_load;
    logic             w_hold_dec;
    logic             w_hold_zero;
    logic [CNT_W-1:0] w_hold_count;

    logic             w_dma_ok;
    logic             w_pending;
    logic             w_rem_one;
    logic             w_hold_one;

    assign w_dma_ok   = dma_req && (dma_count != '0);
    assign w_pending  = cpu_req || IOIP1 || IOIP2;
    assign w_rem_one  = (dma_remaining == CNT_W'(1));
    assign w_hold_one = (w_hold_count == CNT_W'(1));

    always_comb begin
        w_next      = r_state;
        w_fair_next = r_fair;
        w_slot_next = r_slot;
        w_rem_load  = 1'b0;
        w_rem_val   = '0;
        w_rem_dec   = 1'b0;
        w_hold_load = 1'b0;
        w_hold_dec  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_fair && w_dma_ok) begin
                    w_next = S_DMA;
                end else if (cpu_req) begin
                    w_next      = S_CPU;
                    w_slot_next = CNT_W'(CPU_SLOT);
                end else if (IOIP1) begin
                    w_next      = S_IRQ1;
                    w_slot_next = CNT_W'(IRQ_SLOT);
                end else if (IOIP2) begin
                    w_next      = S_IRQ2;
                    w_slot_next = CNT_W'(IRQ_SLOT);
                end else if (w_dma_ok) begin
                    w_next = S_DMA;
                end
                if (w_next == S_DMA) begin
                    w_rem_load  = 1'b1;
                    w_rem_val   = dma_count;
                    w_hold_load = 1'b1;
                    w_fair_next = 1'b0;
                end
            end
            S_CPU, S_IRQ1, S_IRQ2: begin
                if (r_slot <= CNT_W'(1)) begin
                    w_next      = S_IDLE;
                    w_slot_next = '0;
                    w_fair_next = dma_req;
                end else begin
                    w_slot_next = r_slot - CNT_W'(1);
                end
            end
            S_DMA: begin
                if (!dma_req) begin
                    w_next     = S_IDLE;
                    w_rem_load = 1'b1;
                end else if (dma_word_done) begin
                    w_rem_dec  = !w_rem_zero;
                    w_hold_dec = !w_hold_zero;
                    if (w_rem_one) begin
                        w_next = S_IDLE;
                    end else if (w_hold_one) begin
                        // Yield only when someone else is waiting.
                        if (w_pending) w_next = S_IDLE;
                        else           w_hold_load = 1'b1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_fair      <= 1'b0;
            r_slot      <= '0;
            r_cpu_grant <= 1'b0;
            r_grant     <= 1'b0;
            r_ack1      <= 1'b0;
            r_ack2      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_fair      <= w_fair_next;
            r_slot      <= w_slot_next;
            r_cpu_grant <= (w_next == S_CPU);
            r_grant     <= (w_next == S_DMA);
            r_ack1      <= (w_next == S_IRQ1);
            r_ack2      <= (w_next == S_IRQ2);
        end
    end

    arb_burst_counter #(.W(CNT_W)) u_rem (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_rem_load),
        .i_load_val (w_rem_val),
        .i_dec      (w_rem_dec),
        .o_count    (dma_remaining),
        .o_zero     (w_rem_zero)
    );

    arb_burst_counter #(.W(CNT_W)) u_hold (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_hold_load),
        .i_load_val (CNT_W'(DMA_MAX_HOLD)),
        .i_dec      (w_hold_dec),
        .o_count    (w_hold_count),
        .o_zero     (w_hold_zero)
    );

    assign cpu_grant = r_cpu_grant;
    assign grant     = r_grant;
    assign IOAck1    = r_ack1;
    assign IOAck2    = r_ack2;
    assign busybus   = r_grant;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed, table-driven bench for dma_bus_arbiter.
// Owner bits are {cpu_grant, grant, IOAck1, IOAck2}.
module tb_dma_bus_arbiter;

    logic       clock;
    logic       reset_n;
    logic       cpu_req;
    logic       dma_req;
    logic [5:0] dma_count;
    logic       dma_word_done;
    logic       IOIP1;
    logic       IOIP2;
    logic       cpu_grant;
    logic       grant;
    logic       IOAck1;
    logic       IOAck2;
    logic       busybus;
    logic [5:0] dma_remaining;

    int n_chk  = 0;
    int n_pass = 0;

    dma_bus_arbiter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpu_req       (cpu_req),
        .dma_req       (dma_req),
        .dma_count     (dma_count),
        .dma_word_done (dma_word_done),
        .IOIP1         (IOIP1),
        .IOIP2         (IOIP2),
        .cpu_grant     (cpu_grant),
        .grant         (grant),
        .IOAck1        (IOAck1),
        .IOAck2        (IOAck2),
        .busybus       (busybus),
        .dma_remaining (dma_remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       c;
        bit       d;
        int       n;
        bit       dn;
        bit       i1;
        bit       i2;
        bit [3:0] own;
        int       rem;
    } vec_t;

    localparam bit [3:0] O_NONE = 4'b0000;
    localparam bit [3:0] O_CPU  = 4'b1000;
    localparam bit [3:0] O_DMA  = 4'b0100;
    localparam bit [3:0] O_AK1  = 4'b0010;
    localparam bit [3:0] O_AK2  = 4'b0001;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, bit d, int n, bit dn,
                                bit i1, bit i2, bit [3:0] own, int rem);
        vec_t v;
        v.c = c; v.d = d; v.n = n; v.dn = dn;
        v.i1 = i1; v.i2 = i2; v.own = own; v.rem = rem;
        return v;
    endfunction

    task automatic check(input string nm, input bit [3:0] eown,
                         input int erem);
        logic [10:0] act;
        logic [10:0] exp;
        act = {cpu_grant, grant, IOAck1, IOAck2, busybus, dma_remaining};
        exp = {eown, eown[2], 6'(erem)};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", nm, act, exp);
        n_chk++;
        if ($countones(act[10:7]) <= 1) n_pass++;
        else $display("FAIL %s onehot: got %b required at most one", nm, act[10:7]);
    endtask

    task automatic drive(input bit c, input bit d, input int n,
                         input bit dn, input bit i1, input bit i2);
        cpu_req       = c;
        dma_req       = d;
        dma_count     = 6'(n);
        dma_word_done = dn;
        IOIP1         = i1;
        IOIP2         = i2;
    endtask

    task automatic step(input vec_t t, input string nm);
        drive(t.c, t.d, t.n, t.dn, t.i1, t.i2);
        @(posedge clock);
        @(negedge clock);
        check(nm, t.own, t.rem);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("reset", O_NONE, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, O_CPU,  0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, O_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, O_AK1,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, O_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, O_AK2,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_DMA,  5));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_DMA,  4));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_DMA,  3));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_DMA,  2));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_DMA,  1));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, O_DMA,  5));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, O_DMA,  4));
        tbl.push_back(mk(0, 0, 5, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_CPU,  0));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_NONE, 0));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_DMA,  2));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_DMA,  1));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_NONE, 0));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_CPU,  0));
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, O_NONE, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, O_DMA,  2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset while DMA owns the bus.
        step(mk(0, 1, 5, 0, 0, 0, O_DMA, 5), "rst_pre");
        #2 reset_n = 1'b0;
        #1 check("rst_async", O_NONE, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, O_NONE, 0), "rst_idle");
        step(mk(0, 1, 3, 0, 0, 0, O_DMA,  3), "rst_regrant");
        step(mk(0, 0, 0, 0, 0, 0, O_NONE, 0), "rst_abort");

        // Hold counter reloads when nobody else wants the bus.
        step(mk(0, 1, 10, 0, 0, 0, O_DMA, 10), "reload_go");
        for (int k = 1; k <= 10; k++)
            step(mk(0, 1, 10, 1, 0, 0, (k < 10) ? O_DMA : O_NONE, 10 - k),
                 $sformatf("reload_w%0d", k));
        step(mk(0, 0, 0, 0, 0, 0, O_NONE, 0), "reload_end");

        // Yield after DMA_MAX_HOLD words with cpu_req pending.
        step(mk(0, 1, 20, 0, 0, 0, O_DMA, 20), "yield_go");
        for (int k = 1; k <= 8; k++)
            step(mk(k >= 3, 1, 20 - k + 1, 1, 0, 0,
                    (k < 8) ? O_DMA : O_NONE, 20 - k),
                 $sformatf("yield_w%0d", k));
        step(mk(1, 1, 12, 0, 0, 0, O_CPU,  12), "yield_cpu");
        step(mk(1, 1, 12, 0, 0, 0, O_NONE, 12), "yield_turn");
        step(mk(1, 1, 12, 0, 0, 0, O_DMA,  12), "yield_fair");
        step(mk(0, 0, 0, 0, 0, 0, O_NONE, 0),   "yield_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
